div_seq: RTL and testbench

Multi-cycle sequencer for the RV64M divide/remainder path (DIV, DIVU, REM, REMU and the W forms). It sits beside the execute stage: it accepts a level request, runs an iterative restoring divide, and returns a 128-bit `{remainder, quotient}` result with a one-cycle `div_ready` pulse. The execute stage derives `stall_req = div_valid & ~div_ready` from this pulse. The block also owns operand sign handling, RISC-V special-case results, word-op sign extension and pipeline-flush cancellation.

---
 rtl/div_seq.sv | 175 +++++++++++++++++
 tb/tb_div_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Iterative restoring divider for the RV64M DIV/DIVU/REM/REMU and word forms.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow skip CALC.
module div_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         div_valid,
    input  logic         div_32,
    input  logic         div_signed,
    input  logic         flush,
    input  logic [63:0]  dividend,
    input  logic [63:0]  divisor,
    output logic         div_ready,
    output logic [127:0] div_result,
    output logic         div_busy
);

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e       state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [63:0]  rem_q, rem_d;
    logic [63:0]  quo_q, quo_d;
    logic [63:0]  dvs_q, dvs_d;
    logic [63:0]  dvd_q, dvd_d;
    logic         dvd_neg_q, dvd_neg_d;
    logic         dvs_neg_q, dvs_neg_d;
    logic         word_q, word_d;
    logic         sgn_q, sgn_d;
    logic [127:0] res_q, res_d;

    logic         accept;
    logic         in_dvd_neg, in_dvs_neg;
    logic [31:0]  in_dvd_abs32, in_dvs_abs32;
    logic [63:0]  in_dvd_abs64, in_dvs_abs64;

    assign accept       = div_valid & ~flush;
    assign in_dvd_neg   = div_signed & (div_32 ? dividend[31] : dividend[63]);
    assign in_dvs_neg   = div_signed & (div_32 ? divisor[31]  : divisor[63]);
    assign in_dvd_abs32 = in_dvd_neg ? -dividend[31:0] : dividend[31:0];
    assign in_dvs_abs32 = in_dvs_neg ? -divisor[31:0]  : divisor[31:0];
    assign in_dvd_abs64 = in_dvd_neg ? -dividend : dividend;
    assign in_dvs_abs64 = in_dvs_neg ? -divisor  : divisor;

`ifdef DIV_FASTPATH_EN
    logic in_special;
    assign in_special = div_32
        ? ((divisor[31:0] == 32'd0) |
           (div_signed & (dividend[31:0] == 32'h8000_0000) & (divisor[31:0] == 32'hFFFF_FFFF)))
        : ((divisor == 64'd0) |
           (div_signed & (dividend == MIN64) & (divisor == {64{1'b1}})));
`endif

    // Remainder stays below the divisor, so a 65-bit difference never wraps.
    logic [64:0] partial, diff;
    logic        step_ok;
    assign partial = {rem_q, quo_q[63]};
    assign diff    = partial - {1'b0, dvs_q};
    assign step_ok = ~diff[64];

    logic        dvs_zero, ovf;
    logic [63:0] q_raw, q_fix, r_fix;
    logic [63:0] q_sel, r_sel;

    assign dvs_zero = (dvs_q == 64'd0);
    assign ovf      = sgn_q & dvd_neg_q & dvs_neg_q & (dvs_q == 64'd1) &
                      (word_q ? (dvd_q[31:0] == 32'h8000_0000) : (dvd_q == MIN64));
    assign q_raw    = word_q ? {32'd0, quo_q[31:0]} : quo_q;
    assign q_fix    = ((dvd_neg_q ^ dvs_neg_q) & ~dvs_zero) ? -q_raw : q_raw;
    assign r_fix    = dvd_neg_q ? -rem_q : rem_q;

    always_comb begin
        q_sel = q_fix;
        r_sel = r_fix;
        if (dvs_zero) begin
            q_sel = {64{1'b1}};
            r_sel = dvd_q;
        end else if (ovf) begin
            q_sel = dvd_q;
            r_sel = 64'd0;
        end
        if (word_q) begin
            q_sel = {{32{q_sel[31]}}, q_sel[31:0]};
            r_sel = {{32{r_sel[31]}}, r_sel[31:0]};
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        dvd_d     = dvd_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        word_d    = word_q;
        sgn_d     = sgn_q;
        res_d     = res_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d    = div_32;
                    sgn_d     = div_signed;
                    dvd_neg_d = in_dvd_neg;
                    dvs_neg_d = in_dvs_neg;
                    dvd_d     = dividend;
                    rem_d     = 64'd0;
                    quo_d     = div_32 ? {in_dvd_abs32, 32'd0} : in_dvd_abs64;
                    dvs_d     = div_32 ? {32'd0, in_dvs_abs32} : in_dvs_abs64;
                    cnt_d     = div_32 ? 6'd31 : 6'd63;
                    state_d   = CALC;
`ifdef DIV_FASTPATH_EN
                    if (in_special) state_d = FIX;
`endif
                end
            end
            CALC: begin
                rem_d = step_ok ? diff[63:0] : partial[63:0];
                quo_d = {quo_q[62:0], step_ok};
                if (cnt_q == 6'd0) state_d = FIX;
                else               cnt_d   = cnt_q - 6'd1;
            end
            FIX: begin
                res_d   = {r_sel, q_sel};
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A cancelled op must not disturb the previously returned result.
        if (flush) begin
            state_d = IDLE;
            res_d   = res_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            rem_q     <= 64'd0;
            quo_q     <= 64'd0;
            dvs_q     <= 64'd0;
            dvd_q     <= 64'd0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            word_q    <= 1'b0;
            sgn_q     <= 1'b0;
            res_q     <= 128'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            dvd_q     <= dvd_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            word_q    <= word_d;
            sgn_q     <= sgn_d;
            res_q     <= res_d;
        end
    end

    assign div_ready  = (state_q == DONE);
    assign div_busy   = (state_q != IDLE);
    assign div_result = res_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: scoreboard of RISC-V reference results and latencies.
// Latency expectations follow DIV_FASTPATH_EN when it is defined for the build.
module tb_div_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         div_valid = 1'b0;
    logic         div_32 = 1'b0;
    logic         div_signed = 1'b0;
    logic         flush = 1'b0;
    logic [63:0]  dividend = 64'd0;
    logic [63:0]  divisor = 64'd0;
    logic         div_ready;
    logic [127:0] div_result;
    logic         div_busy;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int ready_cnt = 0;

    typedef struct {
        string       tag;
        logic [63:0] q;
        logic [63:0] r;
        int          t;
        int          lat;
    } exp_t;

    exp_t sb[$];

    div_seq dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .div_32     (div_32),
        .div_signed (div_signed),
        .flush      (flush),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_ready  (div_ready),
        .div_result (div_result),
        .div_busy   (div_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (div_ready === 1'b1) ready_cnt <= ready_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension reference semantics, {remainder, quotient}.
    function automatic logic [127:0] model(input bit w, input bit s, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] q, r;
        logic [31:0] a32, b32, q32, r32;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF;
                r32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32;
                r32 = 32'd0;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q = {64{1'b1}};
                r = a;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) begin
                q = a;
                r = 64'd0;
            end else if (s) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
        return {r, q};
    endfunction

    function automatic int exp_lat(input bit w, input bit s, input logic [63:0] a, input logic [63:0] b);
        bit special;
        if (w) special = (b[31:0] == 32'd0) || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        else   special = (b == 64'd0) || (s && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}});
`ifdef DIV_FASTPATH_EN
        if (special) return 2;
`endif
        return w ? 34 : 66;
    endfunction

    // Drive a request; acc_delay is the number of cycles until the DUT can accept it.
    task automatic start_op(input string tag, input bit w, input bit s, input logic [63:0] a,
                            input logic [63:0] b, input bit push, input int acc_delay);
        exp_t        e;
        logic [127:0] m;
        div_valid  = 1'b1;
        div_32     = w;
        div_signed = s;
        dividend   = a;
        divisor    = b;
        if (push) begin
            m     = model(w, s, a, b);
            e.tag = tag;
            e.q   = m[63:0];
            e.r   = m[127:64];
            e.t   = cyc + acc_delay;
            e.lat = exp_lat(w, s, a, b);
            sb.push_back(e);
        end
    endtask

    task automatic wait_result();
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (div_ready !== 1'b1 && n < 300);
        if (div_ready !== 1'b1) begin
            check("ready_timeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            check("spurious_ready", 1, 0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_quot"}, div_result[63:0], e.q);
        check({e.tag, "_rem"}, div_result[127:64], e.r);
        check({e.tag, "_lat"}, cyc - e.t, e.lat);
    endtask

    task automatic run_single(input string tag, input bit w, input bit s, input logic [63:0] a, input logic [63:0] b);
        start_op(tag, w, s, a, b, 1'b1, 0);
        wait_result();
        div_valid = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, div_ready, 0);
    endtask

    initial begin
        int           rc;
        int           t0;
        logic [127:0] held;
        bit           w, s;
        logic [63:0]  a, b;

        #1 rst = 1'b0;
        #2;
        check("rst_ready", div_ready, 0);
        check("rst_busy", div_busy, 0);
        check("rst_result", div_result, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_single("divu_100_7", 1'b0, 1'b0, 64'd100, 64'd7);
        held = model(1'b0, 1'b0, 64'd100, 64'd7);
        repeat (3) @(negedge clk);
        check("result_hold", div_result, held);

        run_single("divw_m7_2", 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        run_single("div_by0", 1'b0, 1'b1, 64'h123, 64'd0);
        run_single("div_ovf", 1'b0, 1'b1, 64'h8000_0000_0000_0000, {64{1'b1}});
        run_single("remw_ovf", 1'b1, 1'b1, 64'h0000_0000_8000_0000, {64{1'b1}});
        run_single("divuw_by0", 1'b1, 1'b0, 64'hDEAD_BEEF_8765_4321, 64'hFFFF_FFFF_0000_0000);
        run_single("div_neg", 1'b0, 1'b1, -64'sd1000, 64'd7);
        run_single("remu_big", 1'b0, 1'b0, {64{1'b1}}, 64'h8000_0000_0000_0001);

        for (int i = 0; i < 8; i++) begin
            w = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = (i % 3 == 0) ? 64'($urandom_range(1, 9)) : {$urandom, $urandom};
            if (i % 4 == 1) b = -b;
            run_single($sformatf("rnd%0d", i), w, s, a, b);
        end

        // Flush at T+10; the replacement op is accepted at T+11.
        rc = ready_cnt;
        start_op("flushed", 1'b0, 1'b0, 64'hFFFF_0000_1234_5678, 64'd5, 1'b0, 0);
        t0 = cyc;
        repeat (10) @(negedge clk);
        check("flush_busy_before", div_busy, 1);
        check("flush_at_t10", cyc - t0, 10);
        flush     = 1'b1;
        div_valid = 1'b0;
        @(negedge clk);
        check("flush_busy", div_busy, 0);
        check("flush_ready", div_ready, 0);
        flush = 1'b0;
        start_op("after_flush", 1'b0, 1'b0, 64'd9, 64'd3, 1'b1, 0);
        wait_result();
        div_valid = 1'b0;
        @(negedge clk);
        check("flush_pulses", ready_cnt - rc, 1);

        // Flush and valid in the same idle cycle: the request is dropped.
        start_op("flush_idle", 1'b0, 1'b0, 64'd50, 64'd5, 1'b0, 0);
        flush = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        div_valid = 1'b0;
        check("flush_idle_busy", div_busy, 0);
        repeat (2) @(negedge clk);
        check("flush_idle_busy2", div_busy, 0);

        // Back-to-back with div_valid held through DONE.
        rc = ready_cnt;
        start_op("b2b_a", 1'b0, 1'b0, 64'd1000, 64'd10, 1'b1, 0);
        wait_result();
        start_op("b2b_b", 1'b1, 1'b0, 64'd77, 64'd5, 1'b1, 1);
        wait_result();
        div_valid = 1'b0;
        @(negedge clk);
        check("b2b_pulses", ready_cnt - rc, 2);

        // Asynchronous reset in the middle of CALC.
        start_op("rst_op", 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd3, 1'b0, 0);
        repeat (20) @(negedge clk);
        check("rst_mid_busy_before", div_busy, 1);
        rc = ready_cnt;
        #2 rst = 1'b0;
        #1;
        check("rst_mid_ready", div_ready, 0);
        check("rst_mid_busy", div_busy, 0);
        check("rst_mid_result", div_result, 0);
        div_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (70) @(negedge clk);
        check("rst_mid_no_ready", ready_cnt - rc, 0);
        check("rst_mid_idle", div_busy, 0);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
